// File: rtl/regfile_tagged.sv
// Tagged architectural register file for an out-of-order core: per-register value, busy bit and ROB tag.
// Optional macro REGFILE_CMT_BYPASS_EN forwards a same-cycle commit onto the read ports.
module regfile_tagged #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int REG_AW  = 5,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              iss_en,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [TAG_W-1:0]  iss_tag,
  input  logic              cmt_en,
  input  logic [REG_AW-1:0] cmt_rd,
  input  logic [TAG_W-1:0]  cmt_tag,
  input  logic [XLEN-1:0]   cmt_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [TAG_W-1:0]  rs2_tag
);

  logic [XLEN-1:0]    r_value [REG_NUM];
  logic [TAG_W-1:0]   r_tag   [REG_NUM];
  logic [REG_NUM-1:0] r_busy;

  logic w_cmt_hit;
  logic w_cmt_clear;
  logic w_iss_hit;

  logic [REG_AW-1:0] w_rd_addr [2];
  logic [XLEN-1:0]   w_rd_data [2];
  logic              w_rd_busy [2];
  logic [TAG_W-1:0]  w_rd_tag  [2];

  // Decode which write-side operations actually touch a real register this cycle.
  always_comb begin
    w_cmt_hit   = cmt_en && (cmt_rd != '0);
    w_iss_hit   = iss_en && (iss_rd != '0) && !flush;
    w_cmt_clear = 1'b0;
    if (w_cmt_hit) begin
      w_cmt_clear = r_busy[cmt_rd] && (r_tag[cmt_rd] == cmt_tag);
    end else begin
      w_cmt_clear = 1'b0;
    end
  end

  // Register state update; issue is applied after commit so it wins busy/tag on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        r_busy <= '0;
      end
      if (w_cmt_hit) begin
        r_value[cmt_rd] <= cmt_data;
        if (w_cmt_clear) begin
          r_busy[cmt_rd] <= 1'b0;
        end
      end
      if (w_iss_hit) begin
        r_busy[iss_rd] <= 1'b1;
        r_tag[iss_rd]  <= iss_tag;
      end
    end
  end

  assign w_rd_addr[0] = rs1_addr;
  assign w_rd_addr[1] = rs2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    // Zero-latency read of stored state; x0 and the reset window always read as zero.
    always_comb begin
      w_rd_data[p] = '0;
      w_rd_busy[p] = 1'b0;
      w_rd_tag[p]  = '0;
      if (rst && (w_rd_addr[p] != '0)) begin
        w_rd_data[p] = r_value[w_rd_addr[p]];
        w_rd_busy[p] = r_busy[w_rd_addr[p]];
        w_rd_tag[p]  = r_tag[w_rd_addr[p]];
`ifdef REGFILE_CMT_BYPASS_EN
        if (cmt_en && rdy && (cmt_rd == w_rd_addr[p])) begin
          w_rd_data[p] = cmt_data;
          if (r_busy[w_rd_addr[p]] && (r_tag[w_rd_addr[p]] == cmt_tag)) begin
            w_rd_busy[p] = 1'b0;
          end else begin
            w_rd_busy[p] = r_busy[w_rd_addr[p]];
          end
        end else begin
          w_rd_data[p] = r_value[w_rd_addr[p]];
        end
`endif
      end else begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
        w_rd_tag[p]  = '0;
      end
    end
  end

  assign rs1_data = w_rd_data[0];
  assign rs1_busy = w_rd_busy[0];
  assign rs1_tag  = w_rd_tag[0];
  assign rs2_data = w_rd_data[1];
  assign rs2_busy = w_rd_busy[1];
  assign rs2_tag  = w_rd_tag[1];

endmodule

// File: doc/regfile_tagged.md
REGFILE_TAGGED -- requirements
Module: regfile_tagged

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers.
REQ-003 SHALL have parameter REG_AW, default 5, register address width (2^REG_AW >= REG_NUM).
REQ-004 SHALL have parameter TAG_W, default 4, reorder-buffer tag width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port rdy, input, 1, global ready; low freezes all state.
REQ-008 SHALL have port flush, input, 1, mispredict flush: clear all busy bits.
REQ-009 SHALL have ports iss_en (1), iss_rd (REG_AW) and iss_tag (TAG_W), all inputs, issue: mark iss_rd busy with iss_tag.
REQ-010 SHALL have ports cmt_en (1), cmt_rd (REG_AW), cmt_tag (TAG_W) and cmt_data (XLEN), all inputs, commit write.
REQ-011 SHALL have ports rs1_addr/rs2_addr (REG_AW) as inputs, and rs1_data/rs2_data (XLEN), rs1_busy/rs2_busy (1) and rs1_tag/rs2_tag (TAG_W) as outputs, two read ports.

Function
REQ-012 SHALL hold per register: value[XLEN], busy[1], tag[TAG_W].
REQ-013 SHALL treat register 0 as hardwired: value 0, busy 0, tag 0; issue/commit to 0 ignored.
REQ-014 SHALL update state only on an edge with rst high and rdy high.
REQ-015 SHALL on commit (cmt_en, cmt_rd!=0) write cmt_data to value[cmt_rd] unconditionally.
REQ-016 SHALL on commit clear busy[cmt_rd] only if busy[cmt_rd]=1 and tag[cmt_rd]==cmt_tag; on tag mismatch, busy/tag SHALL be kept.
REQ-017 SHALL on issue (iss_en, iss_rd!=0, flush low) set busy[iss_rd]=1 and tag[iss_rd]=iss_tag.
REQ-018 SHALL, when issue and commit target the same register in one cycle, give issue priority for busy/tag; the value is still written.
REQ-019 SHALL on flush clear every busy bit; values and tags kept; a commit in the same cycle still writes its value; issue in that cycle is dropped.
REQ-020 SHALL compute reads combinationally, with zero latency: data=value, busy=busy, tag=tag of the addressed register.
REQ-021 SHALL NOT forward issue to read ports: a read in the issue cycle sees pre-issue busy/tag.
REQ-022 SHALL drive read outputs to 0 while rst is low and for address 0.

Reset
REQ-023 SHALL, on an edge with rst low, clear all values, busy bits and tags to 0, regardless of rdy, flush, issue or commit.
REQ-024 SHALL, on reset asserted mid-operation, discard any pending commit in that cycle.

Configuration
REQ-025 SHALL support macro REGFILE_CMT_BYPASS_EN.
REQ-026 SHALL with the macro defined: if cmt_en, rdy and cmt_rd==rsN_addr!=0, return rsN_data=cmt_data; if additionally busy and tag==cmt_tag, return rsN_busy=0.
REQ-027 SHALL without the macro: reads reflect stored state only; committed data is visible from the next cycle.

Verification
REQ-028 SHALL test: reset low 1 cycle, then read x5 -> data 0, busy 0, tag 0.
REQ-029 SHALL test: issue x5 tag 3; next cycle commit x5 tag 3 data 0xDEADBEEF -> after edge x5 = 0xDEADBEEF, busy 0; with macro, the same-cycle read already returns 0xDEADBEEF, busy 0.
REQ-030 SHALL test: issue x7 tag 2, then issue x7 tag 9, then commit x7 tag 2 data 0x11 -> value 0x11, busy 1, tag 9.
REQ-031 SHALL test: issue x4 tag 1 and commit x4 tag 1 data 0x22 in the same cycle (x4 busy, tag 1) -> value 0x22, busy 1, tag 1.
REQ-032 SHALL test: x3, x8 and x9 busy; flush with issue x3 tag 5 -> all busy 0, x3 tag unchanged.
REQ-033 SHALL test: rdy low with commit x6 data 0x55 -> x6 unchanged; commit to x0 data 0xFF -> x0 reads 0.
